// File: rtl/tpu_pkg.sv
// tpu_pkg: shared types for the systolic array result path.
package tpu_pkg;

  localparam int unsigned DEFAULT_ARRAY_WIDTH = 16;

  typedef logic signed [31:0] psum_t;
  typedef logic [15:0]        row_idx_t;

  // One realigned output row as stored in the drain buffer.
  typedef struct packed {
    psum_t [DEFAULT_ARRAY_WIDTH-1:0] data;
    logic  [DEFAULT_ARRAY_WIDTH-1:0] mask;
    row_idx_t                        idx;
  } drain_row_t;

  // Clamp a partial sum at zero.
  function automatic psum_t relu(input psum_t x);
    return x[31] ? '0 : x;
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// drain_fifo: synchronous row FIFO with occupancy count.
// Clear has priority over push and pop. A push while full is only
// accepted when a pop happens in the same cycle.
module drain_fifo
  import tpu_pkg::*;
#(
  parameter type         row_t = drain_row_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  row_t                       push_row,
  input  logic                       pop,
  output row_t                       head_row,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  row_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty && !clear;
  assign do_push  = push && (!full || do_pop) && !clear;
  assign head_row = mem[rd_ptr];

  // Storage array; contents are only observable through valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_row;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// systolic_drain: realigns column-staggered systolic array outputs into
// whole rows, buffers them and offers them over ready/valid.
// Optional build macro SYSTOLIC_DRAIN_RELU_EN clamps enabled columns at
// zero in the aligned stage.
module systolic_drain
  import tpu_pkg::*;
#(
  parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH           = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  psum_t [SYSTOLIC_ARRAY_WIDTH-1:0]      sys_data_out,
  input  logic  [SYSTOLIC_ARRAY_WIDTH-1:0]      sys_valid_out,
  input  logic  [15:0]                          ub_rd_col_size_in,
  input  logic                                  ub_rd_col_size_valid_in,
  input  logic                                  drain_clear_in,
  output psum_t [SYSTOLIC_ARRAY_WIDTH-1:0]      wr_data_out,
  output logic  [SYSTOLIC_ARRAY_WIDTH-1:0]      wr_mask_out,
  output row_idx_t                              wr_row_idx_out,
  output logic                                  wr_valid_out,
  input  logic                                  wr_ready_in,
  output logic  [$clog2(FIFO_DEPTH+1)-1:0]      drain_count_out,
  output logic                                  drain_overflow_out,
  output logic                                  drain_skew_err_out
);

  localparam int unsigned N = SYSTOLIC_ARRAY_WIDTH;

  // Same layout as drain_row_t, sized to this instance's column count.
  typedef struct packed {
    psum_t [N-1:0] data;
    logic  [N-1:0] mask;
    row_idx_t      idx;
  } row_t;

  logic [15:0]   col_size_q;
  logic [N-1:0]  mask_now;
  logic [N-1:0]  dsk_valid;
  psum_t [N-1:0] dsk_data;
  logic [N-1:0]  al_valid;
  logic [N-1:0]  al_mask;
  psum_t [N-1:0] al_data;
  psum_t [N-1:0] al_data_d;
  row_idx_t      row_idx_q;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          skew_now;
  row_t          push_row;
  row_t          head_row;
  logic          fifo_full;
  logic          fifo_empty;

  // Active column count, saturated to the array width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       col_size_q <= '0;
    else if (ub_rd_col_size_valid_in) col_size_q <= (ub_rd_col_size_in > 16'(N)) ? 16'(N)
                                                                                  : ub_rd_col_size_in;
  end

  // Column enable mask derived from the current column count.
  always_comb begin
    mask_now = '0;
    for (int unsigned j = 0; j < N; j++) mask_now[j] = (j < 32'(col_size_q));
  end

  // Deskew: column j is delayed N-1-j cycles so all columns of a row line up.
  for (genvar j = 0; j < N; j++) begin : g_col
    localparam int unsigned D = N - 1 - j;
    if (D == 0) begin : g_direct
      assign dsk_valid[j] = sys_valid_out[j];
      assign dsk_data[j]  = sys_data_out[j];
    end else begin : g_pipe
      logic  [D-1:0] v_sr;
      psum_t [D-1:0] d_sr;
      // Per-column delay line.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_sr <= '0;
          d_sr <= '0;
        end else if (drain_clear_in) begin
          v_sr <= '0;
          d_sr <= '0;
        end else begin
          v_sr[0] <= sys_valid_out[j];
          d_sr[0] <= sys_data_out[j];
          for (int unsigned k = 1; k < D; k++) begin
            v_sr[k] <= v_sr[k-1];
            d_sr[k] <= d_sr[k-1];
          end
        end
      end
      assign dsk_valid[j] = v_sr[D-1];
      assign dsk_data[j]  = d_sr[D-1];
    end
  end

  // Masking (and optional clamp) applied on the way into the aligned register.
  always_comb begin
    al_data_d = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (mask_now[j]) begin
`ifdef SYSTOLIC_DRAIN_RELU_EN
        al_data_d[j] = relu(dsk_data[j]);
`else
        al_data_d[j] = dsk_data[j];
`endif
      end
    end
  end

  // Aligned row register; the mask is captured together with the row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_valid <= '0;
      al_mask  <= '0;
      al_data  <= '0;
    end else if (drain_clear_in) begin
      al_valid <= '0;
      al_mask  <= '0;
      al_data  <= '0;
    end else begin
      al_valid <= dsk_valid;
      al_mask  <= mask_now;
      al_data  <= al_data_d;
    end
  end

  assign push_req = al_valid[0] && (al_mask != '0);
  assign pop      = wr_valid_out && wr_ready_in;
  assign push_ok  = push_req && (!fifo_full || pop);
  assign skew_now = |((al_valid ^ {N{al_valid[0]}}) & al_mask);

  assign push_row.data = al_data;
  assign push_row.mask = al_mask;
  assign push_row.idx  = row_idx_q;

  // Row sequence number and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx_q          <= '0;
      drain_overflow_out <= 1'b0;
      drain_skew_err_out <= 1'b0;
    end else if (drain_clear_in) begin
      row_idx_q          <= '0;
      drain_overflow_out <= 1'b0;
      drain_skew_err_out <= 1'b0;
    end else begin
      if (push_ok)                              row_idx_q          <= row_idx_q + 1'b1;
      if (push_req && fifo_full && !pop)        drain_overflow_out <= 1'b1;
      if (skew_now)                             drain_skew_err_out <= 1'b1;
    end
  end

  drain_fifo #(
    .row_t (row_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (drain_clear_in),
    .push     (push_ok),
    .push_row (push_row),
    .pop      (pop),
    .head_row (head_row),
    .count    (drain_count_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Head row fields read as zero whenever the buffer is empty.
  assign wr_valid_out   = !fifo_empty;
  assign wr_data_out    = fifo_empty ? '0 : head_row.data;
  assign wr_mask_out    = fifo_empty ? '0 : head_row.mask;
  assign wr_row_idx_out = fifo_empty ? '0 : head_row.idx;

endmodule

// File: tb/tb_systolic_drain.sv
// tb_systolic_drain: directed, table-driven bench for systolic_drain (N=4, depth 4).
module tb_systolic_drain;

  localparam int N = 4;
`ifdef SYSTOLIC_DRAIN_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [N-1:0][31:0] din;
  logic [N-1:0]      vin;
  logic [15:0]       size_in;
  logic              size_vld;
  logic              clr;
  logic [N-1:0][31:0] wr_data;
  logic [N-1:0]      wr_mask;
  logic [15:0]       wr_idx;
  logic              wr_valid;
  logic              wr_ready;
  logic [2:0]        cnt;
  logic              ovf;
  logic              skew;

  systolic_drain #(
    .SYSTOLIC_ARRAY_WIDTH (N),
    .FIFO_DEPTH           (4)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .sys_data_out            (din),
    .sys_valid_out           (vin),
    .ub_rd_col_size_in       (size_in),
    .ub_rd_col_size_valid_in (size_vld),
    .drain_clear_in          (clr),
    .wr_data_out             (wr_data),
    .wr_mask_out             (wr_mask),
    .wr_row_idx_out          (wr_idx),
    .wr_valid_out            (wr_valid),
    .wr_ready_in             (wr_ready),
    .drain_count_out         (cnt),
    .drain_overflow_out      (ovf),
    .drain_skew_err_out      (skew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observed popped rows.
  typedef struct {
    logic [N-1:0][31:0] d;
    logic [N-1:0]       m;
    logic [15:0]        idx;
    int                 cyc;
  } obs_t;
  obs_t obs_q[$];

  always begin
    @(negedge clk);
    #2;
    if (rst_n && wr_valid && wr_ready)
      obs_q.push_back('{d: wr_data, m: wr_mask, idx: wr_idx, cyc: cyc});
  end

  function automatic logic [N-1:0][31:0] mk(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // Rows to send in a burst, one new row per cycle.
  logic [N-1:0][31:0] burst [8];
  int t0;

  // Drives nrows staggered rows; column 'late' (if >= 0) arrives one cycle late.
  task automatic drive_burst(input int nrows, input int late);
    int r;
    for (int k = 0; k < nrows + N + 1; k++) begin
      @(negedge clk);
      if (k == 0) t0 = cyc + 1;
      for (int j = 0; j < N; j++) begin
        r = k - j - ((j == late) ? 1 : 0);
        if (r >= 0 && r < nrows) begin
          vin[j] = 1'b1;
          din[j] = burst[r][j];
        end else begin
          vin[j] = 1'b0;
          din[j] = '0;
        end
      end
    end
    @(negedge clk);
    vin = '0;
    din = '0;
  endtask

  task automatic set_size(input logic [15:0] s);
    @(negedge clk);
    size_in  = s;
    size_vld = 1'b1;
    @(negedge clk);
    size_vld = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  typedef struct {
    logic [15:0]        size;
    logic [N-1:0][31:0] din;
    logic [N-1:0][31:0] dexp;
    logic [N-1:0]       mexp;
    logic [15:0]        iexp;
    bit                 none;
  } vec_t;
  vec_t vt [6];

  initial begin
    rst_n = 1'b0; din = '0; vin = '0; size_in = '0; size_vld = 1'b0; clr = 1'b0; wr_ready = 1'b1;

    vt[0] = '{16'd4, mk(100, 101, 102, 103), mk(100, 101, 102, 103), 4'b1111, 16'd0, 1'b0};
    vt[1] = '{16'd2, mk(5, 6, 7, 8),         mk(5, 6, 0, 0),         4'b0011, 16'd1, 1'b0};
    vt[2] = '{16'd9, mk(1, 2, 3, 4),         mk(1, 2, 3, 4),         4'b1111, 16'd2, 1'b0};
    vt[3] = '{16'd1, mk(32'hFFFF_FFFB, 9, 9, 9),
              mk(RELU ? 32'd0 : 32'hFFFF_FFFB, 0, 0, 0),               4'b0001, 16'd3, 1'b0};
    vt[4] = '{16'd0, mk(1, 2, 3, 4),         mk(0, 0, 0, 0),         4'b0000, 16'd4, 1'b1};
    vt[5] = '{16'd4, mk(32'hFFFF_FFFB, 7, 32'hFFFF_FFFF, 0),
              mk(RELU ? 32'd0 : 32'hFFFF_FFFB, 7, RELU ? 32'd0 : 32'hFFFF_FFFF, 0),
                                                                     4'b1111, 16'd4, 1'b0};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(wr_valid), 128'(0));
    chk("rst_data",  128'(wr_data),  128'(0));
    chk("rst_mask",  128'(wr_mask),  128'(0));
    chk("rst_idx",   128'(wr_idx),   128'(0));
    chk("rst_count", 128'(cnt),      128'(0));
    chk("rst_ovf",   128'(ovf),      128'(0));
    chk("rst_skew",  128'(skew),     128'(0));
    rst_n = 1'b1;

    // Single-row vectors.
    for (int v = 0; v < 6; v++) begin
      set_size(vt[v].size);
      obs_q.delete();
      burst[0] = vt[v].din;
      drive_burst(1, -1);
      repeat (4) @(negedge clk);
      if (vt[v].none) begin
        chk($sformatf("v%0d_rows", v), 128'(obs_q.size()), 128'(0));
      end else begin
        chk($sformatf("v%0d_rows", v), 128'(obs_q.size()), 128'(1));
        if (obs_q.size() > 0) begin
          chk($sformatf("v%0d_data", v), 128'(obs_q[0].d),   128'(vt[v].dexp));
          chk($sformatf("v%0d_mask", v), 128'(obs_q[0].m),   128'(vt[v].mexp));
          chk($sformatf("v%0d_idx", v),  128'(obs_q[0].idx), 128'(vt[v].iexp));
          chk($sformatf("v%0d_lat", v),  128'(obs_q[0].cyc), 128'(t0 + N));
        end
      end
    end

    // Back-to-back rows with 2 active columns, index restarted by clear.
    pulse_clear();
    set_size(16'd2);
    obs_q.delete();
    burst[0] = mk(10, 11, 12, 13);
    burst[1] = mk(20, 21, 22, 23);
    drive_burst(2, -1);
    repeat (4) @(negedge clk);
    chk("b2b_rows", 128'(obs_q.size()), 128'(2));
    if (obs_q.size() == 2) begin
      chk("b2b_d0",   128'(obs_q[0].d),   128'(mk(10, 11, 0, 0)));
      chk("b2b_d1",   128'(obs_q[1].d),   128'(mk(20, 21, 0, 0)));
      chk("b2b_m1",   128'(obs_q[1].m),   128'(4'b0011));
      chk("b2b_i0",   128'(obs_q[0].idx), 128'(0));
      chk("b2b_i1",   128'(obs_q[1].idx), 128'(1));
      chk("b2b_lat",  128'(obs_q[0].cyc), 128'(t0 + N));
      chk("b2b_next", 128'(obs_q[1].cyc), 128'(t0 + N + 1));
    end

    // Overflow: five rows into a four-deep buffer with no consumer.
    pulse_clear();
    set_size(16'd4);
    wr_ready = 1'b0;
    obs_q.delete();
    for (int r = 0; r < 5; r++) burst[r] = mk(1000 + r * 10, 1001 + r * 10, 1002 + r * 10, 1003 + r * 10);
    drive_burst(5, -1);
    repeat (3) @(negedge clk);
    chk("ovf_count", 128'(cnt),      128'(4));
    chk("ovf_flag",  128'(ovf),      128'(1));
    chk("ovf_valid", 128'(wr_valid), 128'(1));
    chk("ovf_hidx",  128'(wr_idx),   128'(0));
    @(negedge clk);
    chk("ovf_hold",  128'(wr_data),  128'(mk(1000, 1001, 1002, 1003)));
    wr_ready = 1'b1;
    repeat (8) @(negedge clk);
    chk("ovf_rows", 128'(obs_q.size()), 128'(4));
    for (int r = 0; r < 4; r++) begin
      if (r < obs_q.size()) begin
        chk($sformatf("ovf_idx%0d", r),  128'(obs_q[r].idx), 128'(r));
        chk($sformatf("ovf_d%0d", r),    128'(obs_q[r].d),
            128'(mk(1000 + r * 10, 1001 + r * 10, 1002 + r * 10, 1003 + r * 10)));
      end
    end
    chk("ovf_drained", 128'(cnt),  128'(0));
    chk("ovf_sticky",  128'(ovf),  128'(1));

    // Skew: column 2 one cycle late.
    pulse_clear();
    chk("clr_ovf", 128'(ovf), 128'(0));
    obs_q.delete();
    burst[0] = mk(1, 2, 3, 4);
    drive_burst(1, 2);
    repeat (6) @(negedge clk);
    chk("skew_flag",  128'(skew),          128'(1));
    chk("skew_rows",  128'(obs_q.size()),  128'(1));
    pulse_clear();
    chk("skew_clr",   128'(skew),          128'(0));
    obs_q.delete();
    burst[0] = mk(7, 8, 9, 10);
    drive_burst(1, -1);
    repeat (4) @(negedge clk);
    chk("skew_rows2", 128'(obs_q.size()), 128'(1));
    if (obs_q.size() > 0) chk("skew_idx", 128'(obs_q[0].idx), 128'(0));
    chk("skew_ok", 128'(skew), 128'(0));

    // Asynchronous reset while two rows are in flight.
    obs_q.delete();
    burst[0] = mk(50, 51, 52, 53);
    burst[1] = mk(60, 61, 62, 63);
    fork
      drive_burst(2, -1);
      begin
        repeat (3) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(wr_valid), 128'(0));
        chk("arst_count", 128'(cnt),      128'(0));
        chk("arst_data",  128'(wr_data),  128'(0));
      end
    join
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_rows",  128'(obs_q.size()), 128'(0));
    chk("arst_vld2",  128'(wr_valid),     128'(0));
    chk("arst_skew",  128'(skew),         128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
